// File: rtl/mc_datapath_p_pkg.sv
// Shared encodings and constants for the multicycle ARM-subset datapath.
package mc_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned REG_AW  = 4;
  localparam logic [REG_AW-1:0] R15 = 4'd15;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_ORR  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_MOVB = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_A      = 2'b00,
    SRCA_PC     = 2'b01,
    SRCA_ALUOUT = 2'b10,
    SRCA_ZERO   = 2'b11
  } srca_t;

  typedef enum logic [1:0] {
    SRCB_WD   = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10,
    SRCB_ZERO = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10,
    RES_ZERO      = 2'b11
  } result_t;

  typedef enum logic [1:0] {
    IMM_ZEXT8  = 2'b00,
    IMM_ZEXT12 = 2'b01,
    IMM_BRANCH = 2'b10,
    IMM_ZERO   = 2'b11
  } imm_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/mc_datapath_p_regfile.sv
// 15-entry register file (R0-R14); R15 reads come from the r15 input, writes to R15 are dropped.
module regfile_p
  import mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              stall_n_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [WIDTH-1:0]  wd_i,
  input  logic [REG_AW-1:0] ra1_i,
  input  logic [REG_AW-1:0] ra2_i,
  input  logic [WIDTH-1:0]  r15_i,
  output logic [WIDTH-1:0]  rd1_c_o,
  output logic [WIDTH-1:0]  rd2_c_o
);

  localparam int unsigned NREGS = 15;

  logic [WIDTH-1:0] rf_q [NREGS];
  logic             wr_en;

  assign wr_en = stall_n_i && we_i && (wa_i != R15);

  // Storage is deliberately not reset; software initialises registers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      rf_q[wa_i] <= wd_i;
    end
  end

  assign rd1_c_o = (ra1_i == R15) ? r15_i : rf_q[ra1_i];
  assign rd2_c_o = (ra2_i == R15) ? r15_i : rf_q[ra2_i];

endmodule

// File: rtl/mc_datapath_p.sv
// Multicycle ARM-subset datapath: PC, IR/Data, A/WriteData/ALUOut, regfile, ALU, extender, muxes.
module mc_datapath_p
  import mc_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemReady,
  output logic [WIDTH-1:0]   Adr,
  output logic [WIDTH-1:0]   WriteData,
  input  logic [WIDTH-1:0]   ReadData,
  output logic [INSTR_W-1:0] Instr,
  output logic [FLAGS_W-1:0] ALUFlags,
  input  logic               PCWrite,
  input  logic               RegWrite,
  input  logic               IRWrite,
  input  logic               AdrSrc,
  input  logic [1:0]         RegSrc,
  input  logic [1:0]         ALUSrcA,
  input  logic [1:0]         ALUSrcB,
  input  logic [1:0]         ResultSrc,
  input  logic [1:0]         ImmSrc,
  input  logic [2:0]         ALUControl
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned BR_W  = 26;

  logic                stall_n;
  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0]    aluout_q, aluout_d;

  logic [REG_AW-1:0]   ra1, ra2;
  logic [WIDTH-1:0]    rd1, rd2;
  logic [WIDTH-1:0]    src_a, src_b, b_eff, ext_imm;
  logic [WIDTH-1:0]    alu_result, result;
  logic [SUM_W-1:0]    sum;
  logic                is_sub, arith;
  flags_t              flags;

  assign stall_n = MemReady;

  // Next-state for every holding register; the enable is applied in the flop block.
  always_comb begin
    pc_d     = PCWrite ? result : pc_q;
    instr_d  = IRWrite ? ReadData[INSTR_W-1:0] : instr_q;
    data_d   = ReadData;
    a_d      = rd1;
    wd_d     = rd2;
    aluout_d = alu_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      data_q   <= '0;
      a_q      <= '0;
      wd_q     <= '0;
      aluout_q <= '0;
    end else if (stall_n) begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      data_q   <= data_d;
      a_q      <= a_d;
      wd_q     <= wd_d;
      aluout_q <= aluout_d;
    end
  end

  assign ra1 = RegSrc[0] ? R15 : instr_q[19:16];
  assign ra2 = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];

  regfile_p #(
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk       (clk),
    .stall_n_i (stall_n),
    .we_i      (RegWrite),
    .wa_i      (instr_q[15:12]),
    .wd_i      (result),
    .ra1_i     (ra1),
    .ra2_i     (ra2),
    .r15_i     (result),
    .rd1_c_o   (rd1),
    .rd2_c_o   (rd2)
  );

  // Immediate extender; branch offsets are word offsets sign-extended from bit 23.
  always_comb begin
    ext_imm = '0;
    case (ImmSrc)
      IMM_ZEXT8:  ext_imm = WIDTH'(instr_q[7:0]);
      IMM_ZEXT12: ext_imm = WIDTH'(instr_q[11:0]);
      IMM_BRANCH: ext_imm = {{(WIDTH-BR_W){instr_q[23]}}, instr_q[23:0], 2'b00};
      default:    ext_imm = '0;
    endcase
  end

  always_comb begin
    src_a = '0;
    case (ALUSrcA)
      SRCA_A:      src_a = a_q;
      SRCA_PC:     src_a = pc_q;
      SRCA_ALUOUT: src_a = aluout_q;
      default:     src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (ALUSrcB)
      SRCB_WD:   src_b = wd_q;
      SRCB_IMM:  src_b = ext_imm;
      SRCB_FOUR: src_b = WIDTH'(4);
      default:   src_b = '0;
    endcase
  end

  // Shared adder: SUB is SrcA + ~SrcB + 1, undefined encodings fall back to ADD.
  always_comb begin
    is_sub     = (ALUControl == ALU_SUB);
    b_eff      = is_sub ? ~src_b : src_b;
    sum        = {1'b0, src_a} + {1'b0, b_eff} + SUM_W'(is_sub);
    arith      = 1'b0;
    alu_result = '0;
    case (ALUControl)
      ALU_AND:  alu_result = src_a & src_b;
      ALU_ORR:  alu_result = src_a | src_b;
      ALU_EOR:  alu_result = src_a ^ src_b;
      ALU_MOVB: alu_result = src_b;
      default: begin
        alu_result = sum[WIDTH-1:0];
        arith      = 1'b1;
      end
    endcase
  end

  always_comb begin
    flags.n = alu_result[WIDTH-1];
    flags.z = (alu_result == '0);
    flags.c = arith && sum[WIDTH];
    flags.v = arith && (src_a[WIDTH-1] == b_eff[WIDTH-1])
                    && (sum[WIDTH-1] != src_a[WIDTH-1]);
  end

  always_comb begin
    result = '0;
    case (ResultSrc)
      RES_ALUOUT:    result = aluout_q;
      RES_DATA:      result = data_q;
      RES_ALURESULT: result = alu_result;
      default:       result = '0;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc_q;
  assign WriteData = wd_q;
  assign Instr     = instr_q;
  assign ALUFlags  = flags;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Directed bench for mc_datapath_p: a 32-bit instance (reset vector 0x100) and a 64-bit one (0x200).
module tb_mc_datapath_p;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // 32-bit instance signals
  logic        reset, MemReady, PCWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] ReadData, Adr, WriteData, Instr;
  logic [3:0]  ALUFlags;

  // 64-bit instance signals
  logic        w_reset, w_MemReady, w_PCWrite, w_RegWrite, w_IRWrite, w_AdrSrc;
  logic [1:0]  w_RegSrc, w_ALUSrcA, w_ALUSrcB, w_ResultSrc, w_ImmSrc;
  logic [2:0]  w_ALUControl;
  logic [63:0] w_ReadData, w_Adr, w_WriteData;
  logic [31:0] w_Instr;
  logic [3:0]  w_ALUFlags;

  always #5 clk = ~clk;

  mc_datapath_p #(.WIDTH(32), .RESET_PC(32'h100)) dut32 (
    .clk(clk), .reset(reset), .MemReady(MemReady), .Adr(Adr), .WriteData(WriteData),
    .ReadData(ReadData), .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl)
  );

  mc_datapath_p #(.WIDTH(64), .RESET_PC(64'h200)) dut64 (
    .clk(clk), .reset(w_reset), .MemReady(w_MemReady), .Adr(w_Adr), .WriteData(w_WriteData),
    .ReadData(w_ReadData), .Instr(w_Instr), .ALUFlags(w_ALUFlags), .PCWrite(w_PCWrite),
    .RegWrite(w_RegWrite), .IRWrite(w_IRWrite), .AdrSrc(w_AdrSrc), .RegSrc(w_RegSrc),
    .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ResultSrc(w_ResultSrc), .ImmSrc(w_ImmSrc),
    .ALUControl(w_ALUControl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    MemReady = 1'b1; PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0; AdrSrc = 1'b0;
    RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00; ImmSrc = 2'b00;
    ALUControl = 3'b000;
  endtask

  task automatic w_idle_ctrl();
    w_MemReady = 1'b1; w_PCWrite = 1'b0; w_RegWrite = 1'b0; w_IRWrite = 1'b0; w_AdrSrc = 1'b0;
    w_RegSrc = 2'b00; w_ALUSrcA = 2'b00; w_ALUSrcB = 2'b00; w_ResultSrc = 2'b00;
    w_ImmSrc = 2'b00; w_ALUControl = 3'b000;
  endtask

  task automatic load_ir(input logic [31:0] word);
    IRWrite = 1'b1; ReadData = word;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_ctrl(); ReadData = '0;
    #12;
    checks++; if (Adr !== 32'h100) begin failures++; $display("FAIL reset_adr got=%h exp=%h", Adr, 32'h100); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=%h", Instr, 32'h0); end
    checks++; if (WriteData !== 32'h0) begin failures++; $display("FAIL reset_wd got=%h exp=%h", WriteData, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    load_ir(32'hE3A01005);
    checks++; if (Instr !== 32'hE3A01005) begin failures++; $display("FAIL first_ir got=%h exp=%h", Instr, 32'hE3A01005); end
  endtask

  task automatic test_fetch();
    idle_ctrl();
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCWrite = 1'b1;
    #1;
    checks++; if (ALUFlags !== 4'b0000) begin failures++; $display("FAIL fetch_flags got=%b exp=%b", ALUFlags, 4'b0000); end
    tick();
    PCWrite = 1'b0;
    checks++; if (Adr !== 32'h104) begin failures++; $display("FAIL fetch_pc got=%h exp=%h", Adr, 32'h104); end
  endtask

  task automatic test_stall();
    // R1 <= PC+4 = 0x108, then read it back through WriteData
    idle_ctrl();
    ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; RegSrc = 2'b10; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
    tick();
    checks++; if (WriteData !== 32'h108) begin failures++; $display("FAIL r1_init got=%h exp=%h", WriteData, 32'h108); end
    // Pending PC/R1/IR writes of ALUOut+4 = 0x10C held for three stalled edges
    ALUSrcA = 2'b10; PCWrite = 1'b1; RegWrite = 1'b1; IRWrite = 1'b1;
    ReadData = 32'hE3A01007; MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Adr !== 32'h104) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, Adr, 32'h104); end
      checks++; if (Instr !== 32'hE3A01005) begin failures++; $display("FAIL stall_ir[%0d] got=%h exp=%h", i, Instr, 32'hE3A01005); end
      checks++; if (WriteData !== 32'h108) begin failures++; $display("FAIL stall_wd[%0d] got=%h exp=%h", i, WriteData, 32'h108); end
      AdrSrc = 1'b1; ResultSrc = 2'b00;
      #1;
      checks++; if (Adr !== 32'h108) begin failures++; $display("FAIL stall_aluout[%0d] got=%h exp=%h", i, Adr, 32'h108); end
      AdrSrc = 1'b0; ResultSrc = 2'b10;
      #1;
    end
    MemReady = 1'b1;
    tick();
    PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0;
    checks++; if (Adr !== 32'h10C) begin failures++; $display("FAIL release_pc got=%h exp=%h", Adr, 32'h10C); end
    checks++; if (Instr !== 32'hE3A01007) begin failures++; $display("FAIL release_ir got=%h exp=%h", Instr, 32'hE3A01007); end
    checks++; if (WriteData !== 32'h108) begin failures++; $display("FAIL no_bypass got=%h exp=%h", WriteData, 32'h108); end
    tick();
    checks++; if (WriteData !== 32'h10C) begin failures++; $display("FAIL release_r1 got=%h exp=%h", WriteData, 32'h10C); end
    // A stalled write of zero must not reach R1
    MemReady = 1'b0; RegWrite = 1'b1; ResultSrc = 2'b11;
    tick();
    MemReady = 1'b1; RegWrite = 1'b0; ResultSrc = 2'b10;
    tick();
    checks++; if (WriteData !== 32'h10C) begin failures++; $display("FAIL stall_rf_hold got=%h exp=%h", WriteData, 32'h10C); end
  endtask

  task automatic test_flags();
    logic [2:0]  ops [6];
    logic [31:0] res [6];
    logic [3:0]  nzcv [6];
    ops  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    res  = '{32'h0, 32'h5, 32'h5, 32'h0, 32'h5, 32'hA};
    nzcv = '{4'b0110, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    idle_ctrl();
    load_ir(32'hE3A01001);
    ReadData = 32'h7FFFFFFF;
    tick();
    RegSrc = 2'b01; ResultSrc = 2'b01;
    tick();
    ALUSrcB = 2'b01; ResultSrc = 2'b10; AdrSrc = 1'b1;
    #1;
    checks++; if (Adr !== 32'h80000000) begin failures++; $display("FAIL add_ovf_res got=%h exp=%h", Adr, 32'h80000000); end
    checks++; if (ALUFlags !== 4'b1001) begin failures++; $display("FAIL add_ovf_nzcv got=%b exp=%b", ALUFlags, 4'b1001); end
    AdrSrc = 1'b0;
    load_ir(32'hE3A01005);
    ALUSrcA = 2'b11;
    tick();
    ALUSrcA = 2'b00; AdrSrc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ALUControl = ops[i];
      #1;
      checks++; if (Adr !== res[i]) begin failures++; $display("FAIL op%b_res got=%h exp=%h", ops[i], Adr, res[i]); end
      checks++; if (ALUFlags !== nzcv[i]) begin failures++; $display("FAIL op%b_nzcv got=%b exp=%b", ops[i], ALUFlags, nzcv[i]); end
    end
  endtask

  task automatic test_load();
    idle_ctrl();
    load_ir(32'hE3A03040);
    AdrSrc = 1'b1; ResultSrc = 2'b10; ALUSrcA = 2'b11; ALUSrcB = 2'b01;
    #1;
    checks++; if (Adr !== 32'h40) begin failures++; $display("FAIL load_adr got=%h exp=%h", Adr, 32'h40); end
    ReadData = 32'hDEADBEEF;
    tick();
    AdrSrc = 1'b0; ResultSrc = 2'b01; RegWrite = 1'b1; RegSrc = 2'b10;
    tick();
    RegWrite = 1'b0;
    tick();
    checks++; if (WriteData !== 32'hDEADBEEF) begin failures++; $display("FAIL load_r3 got=%h exp=%h", WriteData, 32'hDEADBEEF); end
    load_ir(32'hE3A0F003);
    RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0; RegSrc = 2'b00;
    tick();
    checks++; if (WriteData !== 32'hDEADBEEF) begin failures++; $display("FAIL r15_wr_r3 got=%h exp=%h", WriteData, 32'hDEADBEEF); end
    RegSrc = 2'b10; ResultSrc = 2'b10; ALUSrcA = 2'b11; ALUSrcB = 2'b10;
    tick();
    checks++; if (WriteData !== 32'h4) begin failures++; $display("FAIL r15_read got=%h exp=%h", WriteData, 32'h4); end
  endtask

  task automatic test_reset_in_stall();
    idle_ctrl();
    MemReady = 1'b0; PCWrite = 1'b1; ALUSrcA = 2'b11; ALUSrcB = 2'b10; ResultSrc = 2'b10;
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (Adr !== 32'h100) begin failures++; $display("FAIL stall_reset_pc got=%h exp=%h", Adr, 32'h100); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("FAIL stall_reset_ir got=%h exp=%h", Instr, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    idle_ctrl();
  endtask

  task automatic test_w64();
    w_idle_ctrl();
    w_IRWrite = 1'b1; w_ReadData = 64'h0000_0000_E3A01001;
    tick();
    w_IRWrite = 1'b0;
    checks++; if (w_Instr !== 32'hE3A01001) begin failures++; $display("FAIL w64_ir got=%h exp=%h", w_Instr, 32'hE3A01001); end
    w_ALUSrcA = 2'b11; w_ALUSrcB = 2'b01; w_ALUControl = 3'b001; w_ResultSrc = 2'b10; w_AdrSrc = 1'b1;
    #1;
    checks++; if (w_Adr !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL w64_sub_res got=%h exp=%h", w_Adr, 64'hFFFF_FFFF_FFFF_FFFF); end
    checks++; if (w_ALUFlags !== 4'b1000) begin failures++; $display("FAIL w64_sub_nzcv got=%b exp=%b", w_ALUFlags, 4'b1000); end
    w_IRWrite = 1'b1; w_ReadData = 64'h0000_0000_EAFF_FFFE;
    tick();
    w_IRWrite = 1'b0; w_ImmSrc = 2'b10; w_ALUControl = 3'b000;
    #1;
    checks++; if (w_Adr !== 64'hFFFF_FFFF_FFFF_FFF8) begin failures++; $display("FAIL w64_branch_imm got=%h exp=%h", w_Adr, 64'hFFFF_FFFF_FFFF_FFF8); end
    w_AdrSrc = 1'b0; w_ALUSrcA = 2'b01; w_ALUSrcB = 2'b10; w_ImmSrc = 2'b00; w_PCWrite = 1'b1;
    tick();
    w_PCWrite = 1'b0;
    checks++; if (w_Adr !== 64'h204) begin failures++; $display("FAIL w64_fetch got=%h exp=%h", w_Adr, 64'h204); end
    #2;
    w_reset = 1'b0;
    #1;
    checks++; if (w_Adr !== 64'h200) begin failures++; $display("FAIL w64_async_pc got=%h exp=%h", w_Adr, 64'h200); end
    checks++; if (w_Instr !== 32'h0) begin failures++; $display("FAIL w64_async_ir got=%h exp=%h", w_Instr, 32'h0); end
    @(negedge clk);
    w_reset = 1'b1;
  endtask

  initial begin
    w_reset = 1'b0; w_idle_ctrl(); w_ReadData = '0;
    test_reset();
    w_reset = 1'b1;
    test_fetch();
    test_stall();
    test_flags();
    test_load();
    test_reset_in_stall();
    test_w64();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
